// File: rtl/param_demux_router.sv
// param_demux_router: registered 1-to-N_CH demultiplexer with valid/ready
// handshakes on the input and on every output lane. Supports explicit select
// and round-robin modes. Beats whose select is out of range are dropped.
// Optional build macro PARAM_DEMUX_CNT_EN adds saturating per-channel beat
// counters and a drop counter.
module param_demux_router #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic                     drop_pulse,
    output logic [SEL_W-1:0]         rr_ptr
`ifdef PARAM_DEMUX_CNT_EN
    ,
    input  logic [SEL_W-1:0]         cnt_sel,
    output logic [15:0]              cnt_out,
    output logic [15:0]              drop_cnt
`endif
);

    // N_CH is widened by one bit so the range compare also works for N_CH == 2**SEL_W.
    localparam logic [SEL_W:0]   N_CH_L = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_L = SEL_W'(N_CH - 1);

    logic                    hold_v_r;
    logic [SEL_W-1:0]        hold_sel_r;
    logic [DATA_W-1:0]       hold_data_r;
    logic [SEL_W-1:0]        rr_ptr_r;
    logic                    drop_r;

    logic                    sel_ready_s;
    logic                    drain_s;
    logic                    accept_s;
    logic [SEL_W-1:0]        eff_s;
    logic                    in_range_s;
    logic [N_CH-1:0]         lane_hit_s;
    logic [N_CH*DATA_W-1:0]  lane_data_s;

    // Ready of the lane currently addressed by the holding register; other lanes are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            sel_ready_s = sel_ready_s | ((hold_sel_r == SEL_W'(k)) & out_ready[k]);
        end
    end

    // Handshake and effective select; the mode input only matters on an accepted beat.
    always_comb begin
        drain_s    = hold_v_r & sel_ready_s;
        in_ready   = ~hold_v_r | sel_ready_s;
        accept_s   = in_valid & in_ready;
        eff_s      = mode ? rr_ptr_r : in_sel;
        in_range_s = ({1'b0, eff_s} < N_CH_L);
    end

    // Decode the holding register onto its lane; all other lanes stay zero.
    always_comb begin
        lane_hit_s  = {N_CH{1'b0}};
        lane_data_s = {(N_CH*DATA_W){1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            lane_hit_s[k] = hold_v_r & (hold_sel_r == SEL_W'(k));
            lane_data_s[k*DATA_W +: DATA_W] = lane_hit_s[k] ? hold_data_r : {DATA_W{1'b0}};
        end
    end

    assign out_valid  = lane_hit_s;
    assign out_data   = lane_data_s;
    assign drop_pulse = drop_r;
    assign rr_ptr     = rr_ptr_r;

    // Holding register, drop flag and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_r    <= 1'b0;
            hold_sel_r  <= {SEL_W{1'b0}};
            hold_data_r <= {DATA_W{1'b0}};
            rr_ptr_r    <= {SEL_W{1'b0}};
            drop_r      <= 1'b0;
        end else begin
            drop_r <= accept_s & ~in_range_s;
            // A dropped beat only gets accepted when the register is empty or draining.
            if (accept_s && in_range_s) begin
                hold_v_r    <= 1'b1;
                hold_sel_r  <= eff_s;
                hold_data_r <= in_data;
            end else if (drain_s) begin
                hold_v_r <= 1'b0;
            end else begin
                hold_v_r <= hold_v_r;
            end
            // Wrap at N_CH-1 so non-power-of-2 channel counts never point out of range.
            if (accept_s && mode) begin
                rr_ptr_r <= (rr_ptr_r == LAST_L) ? {SEL_W{1'b0}} : rr_ptr_r + SEL_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

`ifdef PARAM_DEMUX_CNT_EN
    logic [15:0] cnt_r [N_CH];
    logic [15:0] drop_cnt_r;
    logic [15:0] cnt_out_s;

    // Saturating per-channel drain counters and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_r[k] <= 16'h0000;
            end
            drop_cnt_r <= 16'h0000;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (drain_s && (hold_sel_r == SEL_W'(k)) && (cnt_r[k] != 16'hFFFF)) begin
                    cnt_r[k] <= cnt_r[k] + 16'd1;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
            if (drop_r && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    // Counter readback; a select beyond the last channel reads as zero.
    always_comb begin
        cnt_out_s = 16'h0000;
        for (int k = 0; k < N_CH; k++) begin
            cnt_out_s = cnt_out_s | ((cnt_sel == SEL_W'(k)) ? cnt_r[k] : 16'h0000);
        end
    end

    assign cnt_out  = cnt_out_s;
    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_param_demux_router.sv
// Directed self-checking bench for param_demux_router: one 8-channel instance
// and one 6-channel instance (for out-of-range drops and non-power-of-2 wrap).
module tb_param_demux_router;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8-channel instance
    logic        a_mode, a_in_valid, a_in_ready, a_drop;
    logic [7:0]  a_in_data;
    logic [2:0]  a_in_sel, a_rr_ptr;
    logic [7:0]  a_out_valid, a_out_ready;
    logic [63:0] a_out_data;

    // 6-channel instance
    logic        b_mode, b_in_valid, b_in_ready, b_drop;
    logic [7:0]  b_in_data;
    logic [2:0]  b_in_sel, b_rr_ptr;
    logic [5:0]  b_out_valid, b_out_ready;
    logic [47:0] b_out_data;

`ifdef PARAM_DEMUX_CNT_EN
    logic [2:0]  a_cnt_sel, b_cnt_sel;
    logic [15:0] a_cnt_out, a_drop_cnt, b_cnt_out, b_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    param_demux_router #(.DATA_W(8), .N_CH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .drop_pulse(a_drop), .rr_ptr(a_rr_ptr)
`ifdef PARAM_DEMUX_CNT_EN
        , .cnt_sel(a_cnt_sel), .cnt_out(a_cnt_out), .drop_cnt(a_drop_cnt)
`endif
    );

    param_demux_router #(.DATA_W(8), .N_CH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_pulse(b_drop), .rr_ptr(b_rr_ptr)
`ifdef PARAM_DEMUX_CNT_EN
        , .cnt_sel(b_cnt_sel), .cnt_out(b_cnt_out), .drop_cnt(b_drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_in_sel = 3'd0; a_out_ready = 8'h00;
        b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_in_sel = 3'd0; b_out_ready = 6'h00;
`ifdef PARAM_DEMUX_CNT_EN
        a_cnt_sel = 3'd0; b_cnt_sel = 3'd0;
`endif
        #12;
        check("rst_out_valid", 64'(a_out_valid), 64'h0);
        check("rst_out_data", a_out_data, 64'h0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(a_in_ready), 64'h1);
        check("rst_rr_ptr", 64'(a_rr_ptr), 64'h0);
        check("rst_drop", 64'(a_drop), 64'h0);

        // Explicit select, back-to-back beats with all lanes ready
        a_out_ready = 8'hFF;
        a_in_valid = 1'b1; a_in_sel = 3'd5; a_in_data = 8'hA5;
        step();
        check("exp_valid_ch5", 64'(a_out_valid), 64'h20);
        check("exp_data_ch5", a_out_data, 64'h0000_A500_0000_0000);
        a_in_sel = 3'd0; a_in_data = 8'h3C;
        #1;
        check("exp_no_bubble_ready", 64'(a_in_ready), 64'h1);
        step();
        check("exp_valid_ch0", 64'(a_out_valid), 64'h01);
        check("exp_data_ch0", a_out_data, 64'h0000_0000_0000_003C);
        a_in_valid = 1'b0;
        step();
        check("exp_idle_valid", 64'(a_out_valid), 64'h00);

        // Backpressure on ch2; ready on ch7 must be ignored
        a_out_ready = 8'h80;
        a_in_valid = 1'b1; a_in_sel = 3'd2; a_in_data = 8'h5A;
        step();
        a_in_sel = 3'd4; a_in_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", 64'(a_in_ready), 64'h0);
            check("bp_valid", 64'(a_out_valid), 64'h04);
            check("bp_data", a_out_data, 64'h0000_0000_005A_0000);
            step();
        end
        a_out_ready = 8'h84;
        #1;
        check("bp_release_ready", 64'(a_in_ready), 64'h1);
        step();
        check("bp_replace_valid", 64'(a_out_valid), 64'h10);
        check("bp_replace_data", a_out_data, 64'h0000_0077_0000_0000);
        a_in_valid = 1'b0; a_out_ready = 8'hFF;
        step();

        // Round-robin: 10 beats wrap 7 -> 0; in_sel is ignored
        a_mode = 1'b1; a_in_sel = 3'd7; a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_data = 8'(i);
            #1;
            check("rr_ptr_before", 64'(a_rr_ptr), 64'(i % 8));
            step();
            check("rr_valid", 64'(a_out_valid), 64'h1 << (i % 8));
            check("rr_data", a_out_data, 64'(i) << (8 * (i % 8)));
        end
        check("rr_ptr_after_wrap", 64'(a_rr_ptr), 64'h2);
        a_mode = 1'b0; a_in_sel = 3'd3;
        step();
        step();
        check("rr_hold_mode0", 64'(a_rr_ptr), 64'h2);
        check("mode0_valid_ch3", 64'(a_out_valid), 64'h08);

        // Reset while a beat is held on ch3
        a_out_ready = 8'h00; a_in_data = 8'h99;
        step();
        check("pre_rst_valid", 64'(a_out_valid), 64'h08);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(a_out_valid), 64'h0);
        check("mid_rst_data", a_out_data, 64'h0);
        check("mid_rst_rr", 64'(a_rr_ptr), 64'h0);
        a_in_valid = 1'b0; a_out_ready = 8'hFF;
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 64'(a_in_ready), 64'h1);
        check("post_rst_valid", 64'(a_out_valid), 64'h0);

        // Six channels: selects 6 and 7 are dropped, 5 is delivered
        b_out_ready = 6'h3F; b_mode = 1'b0;
        b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'hFF;
        #1;
        check("drop_in_ready", 64'(b_in_ready), 64'h1);
        step();
        check("drop6_pulse", 64'(b_drop), 64'h1);
        check("drop6_valid", 64'(b_out_valid), 64'h0);
        b_in_sel = 3'd7;
        step();
        check("drop7_pulse", 64'(b_drop), 64'h1);
        check("drop7_valid", 64'(b_out_valid), 64'h0);
        b_in_sel = 3'd5; b_in_data = 8'h42;
        step();
        check("after_drop_pulse", 64'(b_drop), 64'h0);
        check("after_drop_valid", 64'(b_out_valid), 64'h20);
        check("after_drop_data", 64'(b_out_data), 64'h0000_4200_0000_0000);

        // Six channels round-robin wraps at 5
        b_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in_data = 8'(8'h10 + i);
            step();
            check("rr6_valid", 64'(b_out_valid), 64'h1 << i);
        end
        check("rr6_wrap", 64'(b_rr_ptr), 64'h0);
        b_in_valid = 1'b0; b_mode = 1'b0;
        step();

`ifdef PARAM_DEMUX_CNT_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        b_in_valid = 1'b1; b_in_sel = 3'd1; b_in_data = 8'h01;
        step();
        step();
        step();
        b_in_sel = 3'd7;
        step();
        b_in_valid = 1'b0;
        step();
        step();
        b_cnt_sel = 3'd1;
        #1;
        check("cnt_ch1", 64'(b_cnt_out), 64'd3);
        check("drop_cnt", 64'(b_drop_cnt), 64'd1);
        b_cnt_sel = 3'd7;
        #1;
        check("cnt_out_of_range", 64'(b_cnt_out), 64'd0);

        a_mode = 1'b0; a_out_ready = 8'hFF; a_in_sel = 3'd0; a_in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        a_in_valid = 1'b0;
        step();
        a_cnt_sel = 3'd0;
        #1;
        check("cnt_saturate", 64'(a_cnt_out), 64'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_demux_router.md
Name: param_demux_router

Overview:
- Registered, parametrised 1-to-N_CH demultiplexer with valid/ready handshake on the input and on every output channel.
- Generalises the fixed 1-to-8 combinational demux tree to any data width and channel count.
- Adds two selection modes (explicit select, round-robin) and drop handling for out-of-range selects.
- Sits between a single producer and N_CH consumer lanes in the lab datapath.

Parameters:
DATA_W, 8, payload width in bits (>=1)
N_CH, 8, number of output channels (2..256, need not be a power of 2)
SEL_W, $clog2(N_CH), select field width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = explicit select via in_sel, 1 = round-robin
in_valid  input  1  producer beat valid
in_ready  output  1  router can accept beat this cycle
in_data  input  DATA_W  payload
in_sel  input  SEL_W  target channel (used when mode=0)
out_valid  output  N_CH  per-channel valid, at most one bit set
out_ready  input  N_CH  per-channel consumer ready
out_data  output  N_CH*DATA_W  lane k at [k*DATA_W +: DATA_W]; non-selected lanes are 0
drop_pulse  output  1  one-cycle pulse: beat discarded for out-of-range select
rr_ptr  output  SEL_W  current round-robin pointer

Behaviour:
- Single holding register: hold_v, hold_sel, hold_data.
- Reset (async, rst_n=0): hold_v=0, hold_sel=0, hold_data=0, rr_ptr=0, drop_pulse=0; all out_valid=0, out_data=0, in_ready=1 once rst_n=1.
- Outputs: out_valid[hold_sel]=hold_v; lane hold_sel of out_data = hold_data when hold_v=1; every other lane is 0, and all lanes are 0 when hold_v=0.
- in_ready = ~hold_v | out_ready[hold_sel]. This is combinational; pass-through at full throughput, no bubble.
- Accept = in_valid & in_ready. Latency is 1 cycle from accept to out_valid.
- Effective select: eff = in_sel when mode=0, rr_ptr when mode=1. mode is sampled at accept only.
- On accept with eff < N_CH: hold_v<=1, hold_sel<=eff, hold_data<=in_data.
- On accept with eff >= N_CH (mode 0 only, non-power-of-2 N_CH): beat is consumed, not stored. drop_pulse=1 next cycle. The hold register is vacated if it drained the same cycle, otherwise unchanged.
- Drain without accept: hold_v & out_ready[hold_sel] -> hold_v<=0.
- Simultaneous drain and accept: the register is replaced by the new beat, and hold_v stays 1.
- rr_ptr advances only on accept in mode 1: rr_ptr <= (rr_ptr==N_CH-1) ? 0 : rr_ptr+1. It wraps at N_CH-1, not at 2^SEL_W. It holds in mode 0 and is not reset by a mode change.
- out_ready on non-selected channels is ignored.
- Backpressure: hold_v=1 with out_ready[hold_sel]=0 holds hold_data/hold_sel stable and drives in_ready=0.
- Reset mid-transfer: the held beat is lost, outputs clear immediately (async), and rr_ptr returns to 0.

Optional Feature:
Macro: PARAM_DEMUX_CNT_EN
- Defined:
  - Adds input cnt_sel[SEL_W] and outputs cnt_out[16] and drop_cnt[16].
  - Per-channel 16-bit counters increment on each drained beat on that channel and saturate at 16'hFFFF.
  - drop_cnt counts drop_pulse events and saturates.
  - cnt_out = counter[cnt_sel] combinationally; cnt_out = 0 if cnt_sel >= N_CH.
  - All counters reset to 0 on rst_n=0.
- Not defined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 asserted mid-beat (hold_v=1, ch3) -> out_valid=8'h00 and out_data all-zero within the same cycle; after release in_ready=1 and rr_ptr=0.
- Explicit mode, DATA_W=8, N_CH=8, all out_ready=1:
  - Stimulus: in_sel=5, in_data=8'hA5, then in_sel=0, in_data=8'h3C back-to-back.
  - Response: next cycle out_valid=8'h20 with lane5=8'hA5, then out_valid=8'h01 with lane0=8'h3C. No bubble; other lanes 0.
- Backpressure: hold on ch2 with out_ready[2]=0 for 4 cycles, out_ready[7]=1.
  - Response: in_ready=0 for the 4 cycles and lane2 stays stable.
  - When out_ready[2]=1 with new beat valid: replacement happens in the same cycle.
- Round-robin, mode=1: 10 beats 8'h00..8'h09 -> channels 0,1,…,7,0,1 in order; rr_ptr wraps 7->0.
  - Switch to mode=0 for 2 beats -> rr_ptr stays at 2.
- Out-of-range select: N_CH=6, mode=0, in_sel=7, in_data=8'hFF.
  - Response: in_ready=1 and the beat is consumed; drop_pulse=1 for one cycle; out_valid stays 6'b0.
  - A following in_sel=5 beat arrives on lane5.
- With PARAM_DEMUX_CNT_EN:
  - Stimulus: 3 beats to ch1 and 1 drop.
  - Response: cnt_sel=1 gives cnt_out=3, drop_cnt=1.
  - Force 70000 beats to ch0 -> cnt_out saturates at 16'hFFFF.
